// File: rtl/fetch_unit.sv
// fetch_unit
//   Instruction fetch stage. Owns the program counter, reads instruction
//   words from instruction memory over a req/ack handshake, and buffers each
//   fetched word with its byte PC in a DEPTH-entry FIFO. Decode takes
//   {out_inst, out_pc} with a valid/ready handshake. Downstream can redirect
//   the fetch stream; a redirect flushes the FIFO and restarts fetching at
//   the new PC.
//
// Parameters
//   DEPTH     FIFO entries, power of 2 and >= 2
//   RESET_PC  PC after reset, word aligned
//
// Ports
//   clock           rising-edge clock
//   reset           asynchronous, active-low; 0 clears all state
//   imem_req        read request, held until imem_ack
//   imem_addr       word address of the outstanding request (PC[31:2])
//   imem_ack        response strobe, imem_data valid in the same cycle
//   imem_data       fetched instruction word
//   out_valid       FIFO head is valid
//   out_ready       decode accepts the head this cycle
//   out_inst        head instruction word (0 when empty)
//   out_pc          head byte PC (0 when empty)
//   redirect_valid  one-cycle pulse: flush and refetch from redirect_pc
//   redirect_pc     new PC, bits [1:0] ignored
//
// Optional feature (macro FETCH_PERF_EN)
//   Adds perf_delivered (pops) and perf_starve (cycles with out_valid=0 and
//   out_ready=1). Both saturate at all-ones and are cleared only by reset.

module fetch_unit #(
   parameter int          DEPTH    = 4,
   parameter logic [31:0] RESET_PC = 32'h0
) (
   input  logic        clock,
   input  logic        reset,
   output logic        imem_req,
   output logic [29:0] imem_addr,
   input  logic        imem_ack,
   input  logic [31:0] imem_data,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_inst,
   output logic [31:0] out_pc,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc
`ifdef FETCH_PERF_EN
   ,
   output logic [31:0] perf_delivered,
   output logic [31:0] perf_starve
`endif
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   // IDLE: no request outstanding. WAIT: live request outstanding.
   // DROP: request outstanding whose data must be thrown away (redirected).
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      DROP = 2'd2
   } state_t;

   state_t         state;
   state_t         state_next;
   logic [31:0]    pc;
   logic [31:0]    pc_next;
   logic [29:0]    req_addr;
   logic           load_addr;
   logic [31:0]    target_pc;

   logic [31:0]    inst_mem [DEPTH];
   logic [31:0]    pc_mem   [DEPTH];
   logic [PW-1:0]  rd_ptr;
   logic [PW-1:0]  wr_ptr;
   logic [CW-1:0]  count;
   logic [CW-1:0]  count_next;
   logic           push;
   logic           pop;
   logic           space_next;

   // Low two bits of the redirect target are forced to zero.
   assign target_pc = {redirect_pc[31:2], redirect_pc[1:0] & 2'b00};

   assign out_valid = (count != '0);
   assign pop       = out_valid & out_ready;
   // Only a live request may deliver data; a redirect in the same cycle wins.
   assign push      = (state == WAIT) & imem_ack & ~redirect_valid;

   // Occupancy after this edge. The issue decision looks at this value so a
   // pop in the current cycle frees a slot for a request next cycle, and a
   // request is only raised when its data is guaranteed a slot.
   always_comb begin
      count_next = count;
      if (redirect_valid) begin
         count_next = '0;
      end else begin
         count_next = count + CW'(push) - CW'(pop);
      end
   end

   assign space_next = (count_next < CW'(DEPTH));

   assign imem_req  = (state != IDLE);
   assign imem_addr = req_addr;
   assign out_inst  = out_valid ? inst_mem[rd_ptr] : '0;
   assign out_pc    = out_valid ? pc_mem[rd_ptr]   : '0;

   // Next-state and PC logic.
   always_comb begin
      state_next = state;
      pc_next    = pc;
      load_addr  = 1'b0;
      unique case (state)
         IDLE: begin
            if (redirect_valid) begin
               pc_next = target_pc;
            end else if (space_next) begin
               state_next = WAIT;
               load_addr  = 1'b1;
            end
         end
         WAIT: begin
            if (redirect_valid) begin
               pc_next    = target_pc;
               state_next = imem_ack ? IDLE : DROP;
            end else if (imem_ack) begin
               pc_next = pc + 32'd4;
               if (space_next) begin
                  state_next = WAIT;
                  load_addr  = 1'b1;
               end else begin
                  state_next = IDLE;
               end
            end
         end
         DROP: begin
            if (redirect_valid) begin
               pc_next = target_pc;
            end
            if (imem_ack) begin
               state_next = IDLE;
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // Control state, PC, request address and FIFO pointers.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state    <= IDLE;
         pc       <= RESET_PC;
         req_addr <= RESET_PC[31:2];
         rd_ptr   <= '0;
         wr_ptr   <= '0;
         count    <= '0;
      end else begin
         state <= state_next;
         pc    <= pc_next;
         count <= count_next;
         if (load_addr) begin
            req_addr <= pc_next[31:2];
         end
         if (redirect_valid) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
         end else begin
            if (push) begin
               wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
               rd_ptr <= rd_ptr + 1'b1;
            end
         end
      end
   end

   // FIFO storage needs no reset: entries are only visible through
   // out_valid, which derives from the reset count.
   always_ff @(posedge clock) begin
      if (push) begin
         inst_mem[wr_ptr] <= imem_data;
         pc_mem[wr_ptr]   <= {req_addr, 2'b00};
      end
   end

`ifdef FETCH_PERF_EN
   // Saturating performance counters; redirect leaves them alone.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         perf_delivered <= '0;
         perf_starve    <= '0;
      end else begin
         if (pop && (perf_delivered != 32'hFFFF_FFFF)) begin
            perf_delivered <= perf_delivered + 32'd1;
         end
         if (!out_valid && out_ready && (perf_starve != 32'hFFFF_FFFF)) begin
            perf_starve <= perf_starve + 32'd1;
         end
      end
   end
`endif

endmodule
